// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI daisy-chain receive slave.
// Optional feature macro: SPI_DAISY_SLAVE_FRAME_CHECK_EN (adds frame_err).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_slv_state_t;

  localparam int SPI_DATA_W_DEFAULT      = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  // Saturation value of the received-bit counter. With frame checking the
  // counter runs further so over-long frames can be told apart from exact
  // multiples of the word width.
  function automatic int spi_cnt_max(input int data_w);
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
    return (2 * data_w) - 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, followed by a history
// flop that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // Synchroniser chain plus one history flop; all preset to the idle level.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/spi_daisy_slave.sv
// SPI mode-0 MSB-first receive slave with daisy-chain pass-through.
// sclk/cs/mosi are oversampled on clk; completed frames appear on rx_data
// with a one-cycle rx_valid strobe.
// Optional feature macro: SPI_DAISY_SLAVE_FRAME_CHECK_EN (adds frame_err).
module spi_daisy_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              dout,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
  output logic              frame_err,
`endif
  output logic              busy
);

  localparam int CNT_MAX = spi_cnt_max(DATA_W);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_FULL_C = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);

  // Conditioned inputs
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk), .i_rst(rst), .i_d(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(clk), .i_rst(rst), .i_d(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(clk), .i_rst(rst), .i_d(mosi),
    .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // Only edges of sclk/cs and the level of mosi drive the datapath.
  assign w_unused_edges = w_sclk_lvl ^ w_cs_lvl ^ w_mosi_rise ^ w_mosi_fall;

  // State and datapath registers
  spi_slv_state_t    r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_dout, w_dout_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_busy, w_busy_nxt;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
  logic              r_frame_err, w_frame_err_nxt;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; an sclk rise coinciding with a cs rise
  // is shifted in before leaving SHIFT, edges outside SHIFT are dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_cnt_nxt      = r_cnt;
    w_dout_nxt     = r_dout;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
    w_frame_err_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = CNT_ZERO_C;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          w_shreg_nxt = {r_shreg[DATA_W-2:0], w_mosi_lvl};
          if (r_cnt < CNT_MAX_C) begin
            w_cnt_nxt = r_cnt + CNT_ONE_C;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end else begin
          w_shreg_nxt = r_shreg;
        end
        if (w_sclk_fall) begin
          w_dout_nxt = r_shreg[DATA_W-1];
        end else begin
          w_dout_nxt = r_dout;
        end
        if (w_cs_rise) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      DONE: begin
        // A saturated count means at least DATA_W bits arrived; the shift
        // register then holds the last DATA_W of them.
        if (r_cnt >= CNT_FULL_C) begin
          w_rx_data_nxt  = r_shreg;
          w_rx_valid_nxt = 1'b1;
        end else begin
          w_rx_data_nxt  = r_rx_data;
          w_rx_valid_nxt = 1'b0;
        end
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
        // Counts above DATA_W saturate below 2*DATA_W, so any non-zero
        // count other than DATA_W is a partial or misaligned frame.
        if ((r_cnt != CNT_ZERO_C) && (r_cnt != CNT_FULL_C)) begin
          w_frame_err_nxt = 1'b1;
        end else begin
          w_frame_err_nxt = 1'b0;
        end
`endif
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == SHIFT);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg    <= {DATA_W{1'b0}};
      r_cnt      <= CNT_ZERO_C;
      r_dout     <= 1'b0;
      r_rx_data  <= {DATA_W{1'b0}};
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
      r_frame_err <= 1'b0;
`endif
    end else begin
      r_shreg    <= w_shreg_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dout     <= w_dout_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= w_busy_nxt;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
      r_frame_err <= w_frame_err_nxt;
`endif
    end
  end

  assign dout     = r_dout;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_spi_daisy_slave.sv
// Self-checking bench: two chained spi_daisy_slave instances driven with
// directed and random frames, checked against a bit-history reference model.
module tb_spi_daisy_slave;

  logic clk = 1'b0;
  logic rst, sclk, cs, mosi;
  logic dout0, dout1;
  logic [7:0] rx0, rx1;
  logic v0, v1, b0, b1;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
  logic fe0, fe1;
`endif

  always #5 clk = ~clk;

  spi_daisy_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout0), .rx_data(rx0), .rx_valid(v0),
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
    .frame_err(fe0),
`endif
    .busy(b0)
  );

  spi_daisy_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(dout0),
    .dout(dout1), .rx_data(rx1), .rx_valid(v1),
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
    .frame_err(fe1),
`endif
    .busy(b1)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: full history of bits each instance has shifted in.
  // A stage passes on the bit it received 8 sclk periods earlier; the 8
  // leading zeros stand for the cleared shift register after reset.
  bit hist0[$];
  bit hist1[$];
  logic [7:0] exp0, exp1;
  logic busy_mid;

  task automatic model_reset();
    hist0.delete();
    hist1.delete();
    for (int i = 0; i < 8; i++) begin
      hist0.push_back(1'b0);
      hist1.push_back(1'b0);
    end
    exp0 = 8'h00;
    exp1 = 8'h00;
  endtask

  task automatic model_bit(input bit b);
    int len;
    bit fwd;
    len = hist0.size();
    fwd = hist0[len-8];
    hist0.push_back(b);
    hist1.push_back(fwd);
  endtask

  function automatic logic [7:0] last8(input bit q[$]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = q[q.size()-8+i];
    return r;
  endfunction

  function automatic bit exp_err(input int n);
    int c;
    c = (n > 15) ? 15 : n;
    return (c != 0) && (c != 8);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shift n bits of val (MSB first) with a 10-clk sclk period.
  task automatic send_bits(input int n, input logic [31:0] val);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      tick(5);
      sclk = 1'b1;
      model_bit(val[i]);
      tick(5);
      sclk = 1'b0;
      if (i == n - 1) busy_mid = b0;
    end
  endtask

  task automatic run_frame(input int n, input logic [31:0] val);
    cs = 1'b0;
    tick(4);
    send_bits(n, val);
    tick(5);
    cs = 1'b1;
  endtask

  // Watch 10 cycles after cs rises; reports first rx_valid cycle, pulse
  // count, cycles where the two stages disagree and frame_err pulses.
  task automatic observe(output int first, output int hi, output int diff, output int fe);
    first = 0; hi = 0; diff = 0; fe = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (v0 === 1'b1) begin
        hi++;
        if (first == 0) first = k;
      end
      if (v0 !== v1) diff++;
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
      if (fe0 === 1'b1) fe++;
`endif
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sclk = 1'($urandom); cs = 1'($urandom); mosi = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({dout0, rx0, v0, b0, dout1, rx1, v1, b1} !== 22'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got rx0=%h v0=%b b0=%b d0=%b rx1=%h v1=%b b1=%b want all 0",
                 i, rx0, v0, b0, dout0, rx1, v1, b1);
      end
      tick(1);
    end
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(1);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (v0 !== 1'b0 || b0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_release cycle=%0d got v0=%b b0=%b want 0 0", i, v0, b0);
      end
    end
    tick(1);
  endtask

  task automatic test_single();
    int first, hi, diff, fe;
    run_frame(8, 32'hA5);
    observe(first, hi, diff, fe);
    exp0 = last8(hist0); exp1 = last8(hist1);
    checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL single_busy_mid got %b want 1", busy_mid); end
    checks++; if (hi !== 1) begin failures++; $display("FAIL single_pulses got %0d want 1", hi); end
    checks++; if (first !== 4) begin failures++; $display("FAIL single_latency got %0d want 4", first); end
    checks++; if (rx0 !== 8'hA5) begin failures++; $display("FAIL single_data got %h want a5", rx0); end
    checks++; if (rx1 !== exp1) begin failures++; $display("FAIL single_data1 got %h want %h", rx1, exp1); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL single_busy_after got %b want 0", b0); end
  endtask

  task automatic test_short();
    int first, hi, diff, fe;
    run_frame(5, 32'h15);
    observe(first, hi, diff, fe);
    checks++; if (hi !== 0) begin failures++; $display("FAIL short_pulses got %0d want 0", hi); end
    checks++; if (rx0 !== 8'hA5) begin failures++; $display("FAIL short_hold got %h want a5", rx0); end
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
    checks++; if (fe !== 1) begin failures++; $display("FAIL short_frame_err got %0d want 1", fe); end
`endif
  endtask

  task automatic test_daisy();
    int first, hi, diff, fe;
    run_frame(16, 32'h3CC3);
    observe(first, hi, diff, fe);
    exp0 = last8(hist0); exp1 = last8(hist1);
    checks++; if (rx0 !== 8'hC3) begin failures++; $display("FAIL daisy_first got %h want c3", rx0); end
    checks++; if (rx1 !== 8'h3C) begin failures++; $display("FAIL daisy_second got %h want 3c", rx1); end
    checks++; if (diff !== 0 || hi !== 1) begin failures++; $display("FAIL daisy_valid_align got diff=%0d pulses=%0d want 0 1", diff, hi); end
  endtask

  task automatic test_abort();
    int first, hi, diff, fe;
    cs = 1'b0;
    tick(4);
    send_bits(4, 32'hF);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx0, v0, b0, dout0} !== 11'd0) begin
      failures++;
      $display("FAIL abort_reset got rx0=%h v0=%b b0=%b d0=%b want 0", rx0, v0, b0, dout0);
    end
    tick(2);
    cs = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    model_reset();
    run_frame(8, 32'h12);
    observe(first, hi, diff, fe);
    exp0 = last8(hist0); exp1 = last8(hist1);
    checks++; if (rx0 !== 8'h12 || hi !== 1) begin failures++; $display("FAIL abort_data got %h pulses=%0d want 12 1", rx0, hi); end
    checks++; if (rx1 !== exp1) begin failures++; $display("FAIL abort_data1 got %h want %h", rx1, exp1); end
  endtask

  task automatic test_back_to_back();
    int first, hi, diff, fe;
    run_frame(8, 32'h01);
    observe(first, hi, diff, fe);
    checks++; if (rx0 !== 8'h01 || hi !== 1) begin failures++; $display("FAIL b2b_first got %h pulses=%0d want 01 1", rx0, hi); end
    run_frame(8, 32'h80);
    observe(first, hi, diff, fe);
    exp0 = last8(hist0); exp1 = last8(hist1);
    checks++; if (rx0 !== 8'h80 || hi !== 1) begin failures++; $display("FAIL b2b_second got %h pulses=%0d want 80 1", rx0, hi); end
    checks++; if (rx1 !== exp1) begin failures++; $display("FAIL b2b_second1 got %h want %h", rx1, exp1); end
  endtask

  // Last sclk rise lands together with cs rise: the bit must still count.
  task automatic test_simultaneous();
    int first, hi, diff, fe;
    logic [7:0] val;
    val = 8'($urandom);
    cs = 1'b0;
    tick(4);
    send_bits(7, {25'd0, val[7:1]});
    mosi = val[0];
    tick(5);
    sclk = 1'b1;
    cs = 1'b1;
    model_bit(val[0]);
    observe(first, hi, diff, fe);
    sclk = 1'b0;
    checks++; if (rx0 !== val || hi !== 1) begin failures++; $display("FAIL simul_edge got %h pulses=%0d want %h 1", rx0, hi, val); end
    checks++; if (first !== 4) begin failures++; $display("FAIL simul_latency got %0d want 4", first); end
    apply_reset();
  endtask

  task automatic test_random();
    int first, hi, diff, fe, n;
    logic [31:0] val;
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(20, 1);
      val = $urandom;
      run_frame(n, val);
      observe(first, hi, diff, fe);
      if (n >= 8) begin
        exp0 = last8(hist0);
        exp1 = last8(hist1);
      end
      checks++;
      if (hi !== ((n >= 8) ? 1 : 0) || (n >= 8 && first !== 4) || diff !== 0) begin
        failures++;
        $display("FAIL rand_valid frame=%0d n=%0d got pulses=%0d first=%0d diff=%0d", f, n, hi, first, diff);
      end
      checks++;
      if (rx0 !== exp0 || rx1 !== exp1) begin
        failures++;
        $display("FAIL rand_data frame=%0d n=%0d got %h %h want %h %h", f, n, rx0, rx1, exp0, exp1);
      end
`ifdef SPI_DAISY_SLAVE_FRAME_CHECK_EN
      checks++;
      if (fe !== (exp_err(n) ? 1 : 0)) begin
        failures++;
        $display("FAIL rand_frame_err frame=%0d n=%0d got %0d", f, n, fe);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    busy_mid = 1'b0;
    model_reset();
    tick(2);
    test_reset();
    test_single();
    test_short();
    test_daisy();
    test_abort();
    test_back_to_back();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
